// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage ahead of a single-cycle datapath.
// A one-entry tagged buffer answers the current PC combinationally; on a
// miss the FSM fetches the word from instruction memory and refills the
// buffer. Error responses and timeouts load a NOP and set a sticky flag,
// so the core always makes forward progress.
//
// Memory handshake: mem_req/mem_addr are held stable from the first cycle
// of REQ until the cycle mem_gnt is seen high; exactly one response
// (mem_rvalid, qualified by mem_err) follows each grant, no earlier than
// the cycle after the grant. Only one request is ever outstanding.
module instr_fetch_buffer #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] NOP     = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        Stall,
    output logic        FetchErr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic             buf_valid_q, buf_valid_d;
    logic [31:0]      buf_addr_q,  buf_addr_d;
    logic [31:0]      buf_data_q,  buf_data_d;
    logic [31:0]      req_addr_q,  req_addr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             fetch_err_q, fetch_err_d;

    logic hit;

    // Tag compare against the live PC: hits cost zero cycles.
    always_comb begin
        hit   = buf_valid_q && (buf_addr_q == PC);
        Stall = !hit;
        Instr = hit ? buf_data_q : NOP;
    end

    // Request outputs come straight from registered state.
    always_comb begin
        mem_req   = (state_q == ST_REQ);
        mem_addr  = req_addr_q;
        FetchErr  = fetch_err_q;
        dbg_state = state_q;
    end

    // Next-state logic for the fetch FSM, buffer and timeout counter.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        req_addr_d  = req_addr_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    req_addr_d = PC;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                // A response in the grant cycle is illegal and dropped.
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    // A response in the would-be timeout cycle still wins.
                    buf_valid_d = 1'b1;
                    buf_addr_d  = req_addr_q;
                    buf_data_d  = mem_err ? NOP : mem_rdata;
                    if (mem_err) begin
                        fetch_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_LAST) begin
                        // Give up: serve a NOP now, absorb the late reply in DRAIN.
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = NOP;
                        fetch_err_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The late response is discarded; the buffer keeps its NOP.
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            req_addr_q  <= '0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer: directed fetches against a behavioural
// instruction memory with programmable grant/response delays and errors.
// Expected fetch results are queued by the stimulus and checked by a monitor
// whenever Stall falls.
module tb_instr_fetch_buffer;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int EW = 73; // {addr[32], instr[32], ferr[1], stall_cycles[8]}
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC = 32'h0;
    logic [31:0] Instr;
    logic        Stall;
    logic        FetchErr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err = 1'b0;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    instr_fetch_buffer #(.TIMEOUT(16), .NOP(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Instr      (Instr),
        .Stall      (Stall),
        .FetchErr   (FetchErr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic        err_mode  = 1'b0;
    int          m_phase   = 0;   // 0: waiting for request, 1: response owed
    int          m_cnt     = 0;
    int          m_rv_delay = 0;
    logic        m_err     = 1'b0;
    logic [31:0] m_addr    = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h00500093;
            32'h04: return 32'h00A00113;
            32'h08: return 32'h002081B3;
            32'h0C: return 32'h00308233;
            32'h20: return 32'h12345678;
            32'h24: return 32'h40208333;
            32'h30: return 32'h00000513;
            default: return 32'hDEAD0000 | a;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = 32'h0;
            if (reset) begin
                m_phase = 0;
                m_cnt   = 0;
            end else if (m_phase == 0) begin
                if (mem_req) begin
                    if (m_cnt >= gnt_delay) begin
                        mem_gnt    = 1'b1;
                        m_addr     = mem_addr;
                        m_rv_delay = rv_delay;
                        m_err      = err_mode;
                        m_phase    = 1;
                        m_cnt      = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end else begin
                if (m_cnt >= m_rv_delay) begin
                    mem_rvalid = 1'b1;
                    mem_err    = m_err;
                    mem_rdata  = mem_word(m_addr);
                    m_phase    = 0;
                    m_cnt      = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int            stall_cnt;
        logic          prev_req;
        logic          prev_gnt;
        logic [31:0]   prev_addr;
        logic [EW-1:0] e;
        stall_cnt = 0;
        prev_req  = 1'b0;
        prev_gnt  = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                prev_req  = 1'b0;
                prev_gnt  = 1'b0;
                continue;
            end
            if (prev_req && !prev_gnt) begin
                check("req_hold", 32'(mem_req), 32'd1);
                check("addr_hold", mem_addr, prev_addr);
            end
            if (m_phase == 1 && !mem_gnt) begin
                check("no_req_in_flight", 32'(mem_req), 32'd0);
            end
            if (Stall) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_fetch: Instr %h with nothing expected", Instr);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", Instr, e[40:9]);
                    check("fetch_err", 32'(FetchErr), 32'(e[8]));
                    check("stall_cycles", 32'(stall_cnt), 32'(e[7:0]));
                    check("mem_addr", mem_addr, e[72:41]);
                end
                stall_cnt = 0;
            end
            prev_req  = mem_req;
            prev_gnt  = mem_gnt;
            prev_addr = mem_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (Stall && k < 200);
        if (Stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_wait: Stall still 1 after %0d cycles, PC %h", k, PC);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                         input logic ferr, input int stalls);
        exp_q.push_back({pc, instr, ferr, 8'(stalls)});
        @(posedge clk);
        #1;
        PC = pc;
        wait_ready();
    endtask

    task automatic release_fetch(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ferr, input int stalls);
        PC = pc;
        exp_q.push_back({pc, instr, ferr, 8'(stalls)});
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        PC    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(Stall), 32'd1);
        check("rst_instr", Instr, NOP);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_fetch_err", 32'(FetchErr), 32'd0);

        // First fetch after reset: 3 stall cycles.
        release_fetch(32'h0, 32'h00500093, 1'b0, 3);

        // Fetch 0x4, then hold it: every cycle is a hit, no requests.
        fetch(32'h4, 32'h00A00113, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_stall", 32'(Stall), 32'd0);
            check("hold_req", 32'(mem_req), 32'd0);
            check("hold_instr", Instr, 32'h00A00113);
        end

        // Grant delayed by 2: each miss costs 5 stall cycles.
        gnt_delay = 2;
        fetch(32'h0, 32'h00500093, 1'b0, 5);
        fetch(32'h4, 32'h00A00113, 1'b0, 5);
        fetch(32'h8, 32'h002081B3, 1'b0, 5);
        gnt_delay = 0;

        // Response lands in the last cycle before timeout: data wins.
        rv_delay = 15;
        fetch(32'hC, 32'h00308233, 1'b0, 18);

        // Error response: NOP, sticky error.
        rv_delay = 0;
        err_mode = 1'b1;
        fetch(32'h10, NOP, 1'b1, 3);
        err_mode = 1'b0;

        // Timeout after 16 WAIT cycles; the late reply arrives 4 cycles
        // after the next PC is presented, then 0x24 fetches normally.
        rv_delay = 20;
        fetch(32'h20, NOP, 1'b1, 18);
        rv_delay = 0;
        fetch(32'h24, 32'h40208333, 1'b1, 7);

        // Reset while in WAIT abandons the fetch and clears everything.
        rv_delay = 5;
        @(posedge clk);
        #1;
        PC = 32'h30;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_state", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b1;
        PC    = 32'h24;  // was buffered before reset
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(Stall), 32'd1);
        check("midrst_instr", Instr, NOP);
        check("midrst_fetch_err", 32'(FetchErr), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rv_delay = 0;
        release_fetch(32'h30, 32'h00000513, 1'b0, 3);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
